fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/data width.
REQ-002 SHALL have parameter REG_AW, default 3, register address width.
REQ-003 SHALL have parameter NSRC, default 2, source operands per decoded instruction.
REQ-004 SHALL have parameter NFWD, default 2, forwarding stages; index 0 = youngest (EX/MEM), NFWD-1 = oldest (MEM/WB).
REQ-005 SHALL have parameter WDOG, default 8, max consecutive hazard-stall cycles before error.
REQ-006 clk  in  1  single clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 src_addr  in  NSRC*REG_AW  decode-stage source register addresses.
REQ-009 src_used  in  NSRC  operand actually read by instruction.
REQ-010 src_rf_data  in  NSRC*DATA_W  register-file read data.
REQ-011 fwd_wen  in  NFWD  stage k will write a register.
REQ-012 fwd_addr  in  NFWD*REG_AW  stage k destination register.
REQ-013 fwd_rdy  in  NFWD  stage k result available now (0 for load in stage 0).
REQ-014 fwd_data  in  NFWD*DATA_W  stage k result.
REQ-015 stall_in  in  1  external freeze (memory stall); decode holds.
REQ-016 flush  in  1  taken branch/jump; decode instruction squashed.
REQ-017 src_data  out  NSRC*DATA_W  resolved operand values.
REQ-018 haz_stall  out  1  load-use stall request to fetch/decode.
REQ-019 stall_cnt  out  16  saturating count of haz_stall cycles.
REQ-020 err  out  1  sticky watchdog error.

Function
REQ-021 Per source i, match[k] SHALL be fwd_wen[k] & (fwd_addr[k]==src_addr[i]) & src_used[i].
REQ-022 Lowest matching k (youngest) SHALL win; older matches ignored.
REQ-023 Winner with fwd_rdy=1: src_data[i] = fwd_data[k], combinational, same cycle.
REQ-024 Winner with fwd_rdy=0: haz_stall SHALL assert combinationally; src_data[i] don't-care.
REQ-025 No match, hold_vld[i]=1: src_data[i] = hold_data[i]; else src_data[i] = src_rf_data[i].
REQ-026 hold = stall_in | haz_stall; when hold=1 and source i resolved via forwarding (REQ-023), hold_data[i] <= that value, hold_vld[i] <= 1 at next edge.
REQ-027 hold_vld[i] SHALL clear on the edge where hold=0 (decode advances), and on flush.
REQ-028 A new forwarding match while hold_vld[i]=1 SHALL override hold_data and re-capture.
REQ-029 haz_stall SHALL be forced 0 when flush=1 or stall_in=1 (squashed/frozen instruction needs no stall).
REQ-030 stall_cnt SHALL increment by 1 each cycle haz_stall=1, saturate at 16'hFFFF, never wrap.
REQ-031 Watchdog counter SHALL count consecutive haz_stall cycles, reset to 0 on any haz_stall=0 cycle; reaching WDOG SHALL set err, held until rst.
REQ-032 Sources with src_used=0 SHALL never cause haz_stall.
REQ-033 flush and stall_in simultaneous: flush clears hold_vld; haz_stall=0.

Reset
REQ-034 On rst edge: hold_vld=0, hold_data=0, stall_cnt=0, watchdog=0, err=0.
REQ-035 rst mid-stall SHALL discard captured operands; first post-reset cycle uses src_rf_data or live forwarding only.

Structure
REQ-036 Default parameter values and stage-index constants (STG_EXM=0, STG_MWB=1) SHALL live in shared package proc_pkg.
REQ-037 Per-source resolution (match, priority, hold regs) SHALL be sub-module fwd_src_resolve, instantiated NSRC times via generate; counters/watchdog stay in top.

Verification
REQ-038 src_addr0=3, fwd_wen=2'b11, fwd_addr={3,3}, fwd_rdy=2'b11, fwd_data0=16'h1111, fwd_data1=16'h2222 -> src_data0=16'h1111 (youngest wins), haz_stall=0.
REQ-039 Load in stage 0: fwd_wen0=1, fwd_addr0=5, fwd_rdy0=0, src_addr1=5, src_used1=1 -> haz_stall=1, stall_cnt 0->1; next cycle load in stage 1 rdy=1, data 16'hBEEF -> src_data1=16'hBEEF, haz_stall=0.
REQ-040 Same as REQ-039 with src_used1=0 -> haz_stall=0, stall_cnt stays 0.
REQ-041 stall_in=1 with stage1 forwarding r2=16'h00AA; next cycle stage retires (fwd_wen=0), src_rf_data stale 16'h0000 -> src_data=16'h00AA; after stall_in drops and decode advances -> hold cleared, rf data used.
REQ-042 haz_stall forced high WDOG=8 consecutive cycles -> err=1 on 8th edge, stays 1 after haz_stall drops, cleared only by rst.
REQ-043 flush=1 during pending load-use -> haz_stall=0 same cycle, hold_vld=0 next edge.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared defaults and constants for the decode-stage forwarding / hazard logic.
// Stage index 0 is the youngest producer (EX/MEM), the last index the oldest (MEM/WB).
package proc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_NSRC   = 2;
  localparam int DEF_NFWD   = 2;
  localparam int DEF_WDOG   = 8;

  localparam int STG_EXM = 0;
  localparam int STG_MWB = 1;

  localparam int CNT_W = 16;

  // Where a resolved operand comes from this cycle.
  typedef enum logic [1:0] {
    SEL_RF   = 2'd0,
    SEL_FWD  = 2'd1,
    SEL_HOLD = 2'd2,
    SEL_WAIT = 2'd3
  } src_sel_e;

endpackage

// File: rtl/fwd_src_resolve.sv
// Resolves one decode source operand: youngest-wins forwarding match, load-use
// detection, and a hold register that keeps a forwarded value across a decode freeze.
module fwd_src_resolve
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NFWD   = DEF_NFWD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      i_src_addr,
  input  logic                   i_src_used,
  input  logic [DATA_W-1:0]      i_rf_data,
  input  logic [NFWD-1:0]        i_fwd_wen,
  input  logic [NFWD*REG_AW-1:0] i_fwd_addr,
  input  logic [NFWD-1:0]        i_fwd_rdy,
  input  logic [NFWD*DATA_W-1:0] i_fwd_data,
  input  logic                   i_hold,
  input  logic                   i_flush,
  output logic [DATA_W-1:0]      o_src_data,
  output logic                   o_stall_req
);

  logic              w_hit;
  logic              w_win_rdy;
  logic [DATA_W-1:0] w_win_data;
  src_sel_e          w_sel;

  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold_data;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_hit      = 1'b0;
    w_win_rdy  = 1'b0;
    w_win_data = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_fwd_wen[k] && i_src_used &&
          (i_fwd_addr[k*REG_AW +: REG_AW] == i_src_addr)) begin
        w_hit      = 1'b1;
        w_win_rdy  = i_fwd_rdy[k];
        w_win_data = i_fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_sel = SEL_RF;
    if (w_hit && w_win_rdy)  w_sel = SEL_FWD;
    else if (w_hit)          w_sel = SEL_WAIT;
    else if (r_hold_vld)     w_sel = SEL_HOLD;
  end

  always_comb begin
    o_src_data = i_rf_data;
    case (w_sel)
      SEL_FWD:  o_src_data = w_win_data;
      SEL_HOLD: o_src_data = r_hold_data;
      default:  o_src_data = i_rf_data;
    endcase
  end

  assign o_stall_req = (w_sel == SEL_WAIT);

  // The hold register only lives while decode is frozen; any advance or squash drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (i_flush || !i_hold) begin
      r_hold_vld  <= 1'b0;
    end else if (w_sel == SEL_FWD) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= w_win_data;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding and load-use hazard unit with a saturating
// stall counter and a sticky watchdog on consecutive hazard stalls.
module fwd_hazard_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NSRC   = DEF_NSRC,
  parameter int NFWD   = DEF_NFWD,
  parameter int WDOG   = DEF_WDOG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_used,
  input  logic [NSRC*DATA_W-1:0] src_rf_data,
  input  logic [NFWD-1:0]        fwd_wen,
  input  logic [NFWD*REG_AW-1:0] fwd_addr,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic                   stall_in,
  input  logic                   flush,
  output logic [NSRC*DATA_W-1:0] src_data,
  output logic                   haz_stall,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic                   err
);

  localparam int WD_W = $clog2(WDOG + 1);

  logic [NSRC-1:0]  w_stall_req;
  logic             w_hold;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_err;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      fwd_src_resolve #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .NFWD   (NFWD)
      ) u_resolve (
        .clk         (clk),
        .rst         (rst),
        .i_src_addr  (src_addr[i*REG_AW +: REG_AW]),
        .i_src_used  (src_used[i]),
        .i_rf_data   (src_rf_data[i*DATA_W +: DATA_W]),
        .i_fwd_wen   (fwd_wen),
        .i_fwd_addr  (fwd_addr),
        .i_fwd_rdy   (fwd_rdy),
        .i_fwd_data  (fwd_data),
        .i_hold      (w_hold),
        .i_flush     (flush),
        .o_src_data  (src_data[i*DATA_W +: DATA_W]),
        .o_stall_req (w_stall_req[i])
      );
    end
  endgenerate

  // A squashed or externally frozen instruction has no reason to request a stall.
  assign haz_stall = (|w_stall_req) & ~flush & ~stall_in;
  assign w_hold    = stall_in | haz_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_wdog      <= '0;
      r_err       <= 1'b0;
    end else if (haz_stall) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_wdog != WD_W'(WDOG)) r_wdog <= r_wdog + WD_W'(1);
      if (r_wdog == WD_W'(WDOG - 1)) r_err <= 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: the driver pushes hand-computed expectations
// each cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_hazard_unit;

  localparam int M_D0  = 1;
  localparam int M_D1  = 2;
  localparam int M_ST  = 4;
  localparam int M_CNT = 8;
  localparam int M_ERR = 16;

  logic        clk;
  logic        rst;
  logic [5:0]  src_addr;
  logic [1:0]  src_used;
  logic [31:0] src_rf_data;
  logic [1:0]  fwd_wen;
  logic [5:0]  fwd_addr;
  logic [1:0]  fwd_rdy;
  logic [31:0] fwd_data;
  logic        stall_in;
  logic        flush;
  logic [31:0] src_data;
  logic        haz_stall;
  logic [15:0] stall_cnt;
  logic        err;

  typedef struct packed {
    logic [4:0]  mask;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        stall;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total;
  int    bad;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .src_rf_data (src_rf_data),
    .fwd_wen     (fwd_wen),
    .fwd_addr    (fwd_addr),
    .fwd_rdy     (fwd_rdy),
    .fwd_data    (fwd_data),
    .stall_in    (stall_in),
    .flush       (flush),
    .src_data    (src_data),
    .haz_stall   (haz_stall),
    .stall_cnt   (stall_cnt),
    .err         (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_addr    = '0;
    src_used    = '0;
    src_rf_data = {16'hB1B1, 16'hA0A0};
    fwd_wen     = '0;
    fwd_addr    = '0;
    fwd_rdy     = '0;
    fwd_data    = '0;
    stall_in    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [2:0] addr, input logic used,
                         input logic [15:0] rf);
    src_addr[i*3 +: 3]     = addr;
    src_used[i]            = used;
    src_rf_data[i*16 +: 16] = rf;
  endtask

  task automatic set_fwd(input int k, input logic wen, input logic [2:0] addr,
                         input logic rdy, input logic [15:0] data);
    fwd_wen[k]           = wen;
    fwd_addr[k*3 +: 3]   = addr;
    fwd_rdy[k]           = rdy;
    fwd_data[k*16 +: 16] = data;
  endtask

  task automatic expect_now(input string nm, input int mask, input logic [15:0] d0,
                            input logic [15:0] d1, input logic st,
                            input logic [15:0] cnt, input logic er);
    exp_t e;
    e.mask  = mask[4:0];
    e.d0    = d0;
    e.d1    = d1;
    e.stall = st;
    e.cnt   = cnt;
    e.err   = er;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string nm, input string field, input logic [15:0] act,
                       input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s.%s: got=%h expected=%h @%0t", nm, field, act, exp_v, $time);
    end
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.mask[0]) check(nm, "src_data0", src_data[15:0], e.d0);
        if (e.mask[1]) check(nm, "src_data1", src_data[31:16], e.d1);
        if (e.mask[2]) check(nm, "haz_stall", {15'd0, haz_stall}, {15'd0, e.stall});
        if (e.mask[3]) check(nm, "stall_cnt", stall_cnt, e.cnt);
        if (e.mask[4]) check(nm, "err", {15'd0, err}, {15'd0, e.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int drain;
    total = 0;
    bad   = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_now("reset", M_D0 | M_D1 | M_ST | M_CNT | M_ERR, 16'hA0A0, 16'hB1B1, 1'b0, 16'd0, 1'b0);

    // youngest of two ready matches wins
    tick();
    set_src(0, 3'd3, 1'b1, 16'hA0A0);
    set_src(1, 3'd1, 1'b1, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd3, 1'b1, 16'h1111);
    set_fwd(1, 1'b1, 3'd3, 1'b1, 16'h2222);
    expect_now("youngest_wins", M_D0 | M_D1 | M_ST | M_CNT, 16'h1111, 16'hB1B1, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(0, 1'b0, 3'd3, 1'b1, 16'h1111);
    expect_now("older_only", M_D0 | M_ST, 16'h2222, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(0, 1'b1, 3'd1, 1'b1, 16'h3333);
    expect_now("split_match", M_D0 | M_D1, 16'h2222, 16'h3333, 1'b0, 16'd0, 1'b0);

    // load-use on source 1, then the load moves to stage 1 and forwards
    tick();
    idle();
    set_src(1, 3'd5, 1'b1, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd5, 1'b0, 16'hDEAD);
    expect_now("load_use", M_D0 | M_ST | M_CNT, 16'hA0A0, 16'h0, 1'b1, 16'd0, 1'b0);
    tick();
    set_fwd(0, 1'b0, 3'd0, 1'b0, 16'h0);
    set_fwd(1, 1'b1, 3'd5, 1'b1, 16'hBEEF);
    expect_now("load_fwd", M_D1 | M_ST | M_CNT, 16'h0, 16'hBEEF, 1'b0, 16'd1, 1'b0);
    tick();
    idle();
    expect_now("after_load", M_D1 | M_ST | M_CNT, 16'h0, 16'hB1B1, 1'b0, 16'd1, 1'b0);

    // unused source never stalls
    tick();
    set_src(1, 3'd5, 1'b0, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd5, 1'b0, 16'hDEAD);
    expect_now("unused_src", M_D1 | M_ST | M_CNT, 16'h0, 16'hB1B1, 1'b0, 16'd1, 1'b0);
    tick();
    idle();
    expect_now("unused_cnt", M_CNT, 16'h0, 16'h0, 1'b0, 16'd1, 1'b0);

    // youngest match not ready stalls even though an older stage is ready
    tick();
    set_src(0, 3'd6, 1'b1, 16'hA0A0);
    set_fwd(0, 1'b1, 3'd6, 1'b0, 16'h0);
    set_fwd(1, 1'b1, 3'd6, 1'b1, 16'h6666);
    expect_now("young_not_rdy", M_ST | M_CNT, 16'h0, 16'h0, 1'b1, 16'd1, 1'b0);
    tick();
    idle();
    expect_now("young_cnt", M_ST | M_CNT, 16'h0, 16'h0, 1'b0, 16'd2, 1'b0);

    // external freeze masks the hazard
    tick();
    set_src(1, 3'd5, 1'b1, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd5, 1'b0, 16'h0);
    stall_in = 1'b1;
    expect_now("stall_in_mask", M_ST | M_CNT, 16'h0, 16'h0, 1'b0, 16'd2, 1'b0);
    tick();
    idle();
    expect_now("stall_in_cnt", M_CNT, 16'h0, 16'h0, 1'b0, 16'd2, 1'b0);

    // hold register keeps a forwarded value while frozen, re-captures on a newer match
    tick();
    stall_in = 1'b1;
    set_src(0, 3'd2, 1'b1, 16'h0000);
    set_fwd(1, 1'b1, 3'd2, 1'b1, 16'h00AA);
    expect_now("hold_cap", M_D0 | M_ST, 16'h00AA, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(1, 1'b0, 3'd0, 1'b0, 16'h0);
    expect_now("hold_use", M_D0, 16'h00AA, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(0, 1'b1, 3'd2, 1'b1, 16'h1234);
    expect_now("hold_override", M_D0, 16'h1234, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(0, 1'b0, 3'd0, 1'b0, 16'h0);
    expect_now("hold_recap", M_D0, 16'h1234, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    stall_in = 1'b0;
    expect_now("hold_last", M_D0, 16'h1234, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    expect_now("hold_cleared", M_D0, 16'h0000, 16'h0, 1'b0, 16'd0, 1'b0);

    // flush together with stall_in clears the hold and masks the hazard
    tick();
    idle();
    stall_in = 1'b1;
    set_src(0, 3'd4, 1'b1, 16'h0F0F);
    set_fwd(1, 1'b1, 3'd4, 1'b1, 16'h5555);
    expect_now("flush_pre", M_D0, 16'h5555, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    set_fwd(1, 1'b0, 3'd0, 1'b0, 16'h0);
    set_src(1, 3'd5, 1'b1, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd5, 1'b0, 16'h0);
    flush = 1'b1;
    expect_now("flush_stall_in", M_D0 | M_ST | M_CNT, 16'h5555, 16'h0, 1'b0, 16'd2, 1'b0);
    tick();
    flush = 1'b0;
    set_fwd(0, 1'b0, 3'd0, 1'b0, 16'h0);
    expect_now("flush_cleared", M_D0, 16'h0F0F, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    idle();
    set_src(1, 3'd5, 1'b1, 16'hB1B1);
    set_fwd(0, 1'b1, 3'd5, 1'b0, 16'h0);
    flush = 1'b1;
    expect_now("flush_load_use", M_ST | M_CNT, 16'h0, 16'h0, 1'b0, 16'd2, 1'b0);
    tick();
    idle();
    expect_now("flush_cnt", M_CNT, 16'h0, 16'h0, 1'b0, 16'd2, 1'b0);

    // reset mid-freeze discards the captured operand
    tick();
    stall_in = 1'b1;
    set_src(0, 3'd6, 1'b1, 16'h1357);
    set_fwd(1, 1'b1, 3'd6, 1'b1, 16'h7777);
    expect_now("rst_pre", M_D0, 16'h7777, 16'h0, 1'b0, 16'd0, 1'b0);
    tick();
    rst = 1'b1;
    set_fwd(1, 1'b0, 3'd0, 1'b0, 16'h0);
    tick();
    rst = 1'b0;
    expect_now("rst_discard", M_D0 | M_CNT | M_ERR, 16'h1357, 16'h0, 1'b0, 16'd0, 1'b0);

    // watchdog: a 7-cycle run is harmless, an 8-cycle run sets err for good
    for (int j = 0; j < 7; j++) begin
      tick();
      idle();
      set_src(1, 3'd5, 1'b1, 16'hB1B1);
      set_fwd(0, 1'b1, 3'd5, 1'b0, 16'h0);
      expect_now("wd_run7", M_ST | M_CNT | M_ERR, 16'h0, 16'h0, 1'b1, 16'(j), 1'b0);
    end
    tick();
    idle();
    expect_now("wd_break", M_ST | M_CNT | M_ERR, 16'h0, 16'h0, 1'b0, 16'd7, 1'b0);
    for (int j = 0; j < 8; j++) begin
      tick();
      set_src(1, 3'd5, 1'b1, 16'hB1B1);
      set_fwd(0, 1'b1, 3'd5, 1'b0, 16'h0);
      expect_now("wd_run8", M_ST | M_CNT | M_ERR, 16'h0, 16'h0, 1'b1, 16'(7 + j), 1'b0);
    end
    tick();
    idle();
    expect_now("wd_err", M_ST | M_CNT | M_ERR, 16'h0, 16'h0, 1'b0, 16'd15, 1'b1);
    tick();
    expect_now("wd_sticky", M_CNT | M_ERR, 16'h0, 16'h0, 1'b0, 16'd15, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_now("wd_rst", M_CNT | M_ERR, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0);

    // bounded drain of outstanding expectations
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      tick();
      drain++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
